// File: rtl/bus_master_port_if.sv
// Handshake and serial-bus bundle between local logic, the bus master port
// and the serial memory slave.
interface bus_master_port_if #(
  parameter int N   = 8,
  parameter int ADN = 12
) ();
  logic           req_valid;
  logic           req_wren;
  logic [ADN-1:0] req_addr;
  logic [N-1:0]   req_wdata;
  logic           req_ready;
  logic           rsp_valid;
  logic [N-1:0]   rsp_rdata;
  logic           rsp_err;
  logic           bus_valid;
  logic           bus_wren;
  logic           bus_addr;
  logic           bus_wdata;
  logic           bus_ready;
  logic           bus_hold;
  logic           bus_rvalid;
  logic           bus_rdata;

  modport master (
    input  req_valid, req_wren, req_addr, req_wdata,
    input  bus_ready, bus_hold, bus_rvalid, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_valid, bus_wren, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_wren, req_addr, req_wdata,
    output bus_ready, bus_hold, bus_rvalid, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_valid, bus_wren, bus_addr, bus_wdata
  );
endinterface

// File: rtl/bus_master_port.sv
// Serial bus initiator: serialises a parallel read/write request MSB-first
// onto the one-bit bus, collects the read byte and returns a one-cycle
// response. A watchdog aborts reads the slave never answers.
module bus_master_port #(
  parameter int N       = 8,
  parameter int ADN     = 12,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rstn,
  bus_master_port_if.master bif
);
  localparam int CW = $clog2(ADN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] ADDR    = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(N - 1);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT);
  // ADDR cycle index that carries the write-data MSB (data is right-aligned)
  localparam int            WD_FIRST  = ADN - N;

  logic [2:0]     state;
  logic [ADN-1:0] addr_sh;
  logic [N-1:0]   wdata_sh;
  logic [N-1:0]   rdata_sh;
  logic           wren_r;
  logic [CW-1:0]  cnt;
  logic [WW-1:0]  wdog;
  logic [N-1:0]   rdata_next;
  logic           data_slot;

  // Requests are only taken in IDLE while the slave is ready; held low in reset
  assign bif.req_ready = rstn & bif.bus_ready & (state == IDLE);

  // Decide whether the ADDR cycle about to be presented carries a write-data bit
  always_comb begin
    data_slot  = 1'b0;
    rdata_next = (rdata_sh << 1) | N'(bif.bus_rdata);
    if (state == START) data_slot = (WD_FIRST == 0);
    else                data_slot = ((int'(cnt) + 1) >= WD_FIRST);
  end

  // Transaction sequencer; every output is registered on the transition into its state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      addr_sh       <= '0;
      wdata_sh      <= '0;
      rdata_sh      <= '0;
      wren_r        <= 1'b0;
      cnt           <= '0;
      wdog          <= '0;
      bif.rsp_valid <= 1'b0;
      bif.rsp_rdata <= '0;
      bif.rsp_err   <= 1'b0;
      bif.bus_valid <= 1'b0;
      bif.bus_wren  <= 1'b0;
      bif.bus_addr  <= 1'b0;
      bif.bus_wdata <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bif.rsp_valid <= 1'b0;
          bif.rsp_rdata <= '0;
          bif.rsp_err   <= 1'b0;
          if (bif.req_valid && bif.bus_ready) begin
            addr_sh       <= bif.req_addr;
            wdata_sh      <= bif.req_wdata;
            wren_r        <= bif.req_wren;
            rdata_sh      <= '0;
            cnt           <= '0;
            wdog          <= '0;
            bif.bus_valid <= 1'b1;
            bif.bus_wren  <= bif.req_wren;
            bif.bus_addr  <= 1'b0;
            bif.bus_wdata <= 1'b0;
            state         <= START;
          end
        end
        START, ADDR: begin
          if (state == ADDR && cnt == ADDR_LAST) begin
            bif.bus_valid <= 1'b0;
            bif.bus_wren  <= 1'b0;
            bif.bus_addr  <= 1'b0;
            bif.bus_wdata <= 1'b0;
            cnt           <= '0;
            wdog          <= '0;
            state         <= wren_r ? WR_WAIT : RD_WAIT;
          end else begin
            cnt          <= (state == START) ? '0 : cnt + 1'b1;
            bif.bus_addr <= addr_sh[ADN-1];
            addr_sh      <= addr_sh << 1;
            if (wren_r && data_slot) begin
              bif.bus_wdata <= wdata_sh[N-1];
              wdata_sh      <= wdata_sh << 1;
            end else begin
              bif.bus_wdata <= 1'b0;
            end
            state <= ADDR;
          end
        end
        WR_WAIT: begin
          if (bif.bus_ready) begin
            bif.rsp_valid <= 1'b1;
            bif.rsp_rdata <= '0;
            bif.rsp_err   <= 1'b0;
            state         <= DONE;
          end
        end
        RD_WAIT: begin
          if (bif.bus_rvalid) begin
            cnt   <= '0;
            state <= RD_DATA;
          end else if (wdog == WD_LIMIT) begin
            bif.rsp_valid <= 1'b1;
            bif.rsp_rdata <= '0;
            bif.rsp_err   <= 1'b1;
            state         <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RD_DATA: begin
          if (bif.bus_rvalid) begin
            rdata_sh <= rdata_next;
            if (cnt == DATA_LAST) begin
              bif.rsp_valid <= 1'b1;
              bif.rsp_rdata <= rdata_next;
              bif.rsp_err   <= 1'b0;
              state         <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            bif.rsp_valid <= 1'b1;
            bif.rsp_rdata <= '0;
            bif.rsp_err   <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bif.rsp_valid <= 1'b0;
          bif.rsp_rdata <= '0;
          bif.rsp_err   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
